// File: rtl/salsa_keystream_ctrl.sv
// Salsa20 keystream sequencer around an external salsa_hash core.
// Define SALSA_KS_PREFETCH_EN for a shadow digest buffer (no inter-block bubble).
module salsa_keystream_ctrl #(
  parameter int HASH_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [255:0] cfg_key,
  input  logic [63:0]  cfg_nonce,
  input  logic [63:0]  cfg_counter,
  input  logic         stop,
  output logic [255:0] hash_key_out,
  output logic [63:0]  hash_nonce_out,
  output logic [63:0]  hash_counter_out,
  input  logic [511:0] hash_digest_in,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [31:0]  ks_data,
  output logic         ks_last,
  output logic         busy,
  output logic         ctr_wrap
);

  typedef enum logic [1:0] {
    IDLE,
    HASH,
    STREAM
  } state_t;

  localparam logic [3:0]  LAT_M1  = 4'(HASH_LAT - 1);
  localparam logic [63:0] CTR_MAX = '1;

  state_t       state;
  state_t       state_nx;
  logic [3:0]   lat_cnt;
  logic [3:0]   idx;
  logic [511:0] blk_q;

  logic accept;
  logic xfer;
  logic last_xfer;
  logic hash_done;
  logic ctr_max;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign ks_valid  = (state == STREAM);
  assign ks_data   = blk_q[511:480];
  assign ks_last   = ks_valid && (idx == 4'd15);

  assign accept    = cfg_valid && cfg_ready;
  assign xfer      = ks_valid && ks_ready;
  assign last_xfer = xfer && ks_last;
  assign hash_done = (state == HASH) && (lat_cnt == LAT_M1);
  assign ctr_max   = (hash_counter_out == CTR_MAX);

`ifdef SALSA_KS_PREFETCH_EN
  logic [511:0] shadow_q;
  logic         sh_valid;
  logic         pf_busy;
  logic         pf_issued;
  logic [3:0]   pf_cnt;
  logic         swap;
  logic         pf_start;

  assign swap     = last_xfer && !stop && pf_issued && sh_valid;
  assign pf_start = (hash_done && !stop) || swap;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cfg_valid) state_nx = HASH;
      end
      HASH: begin
        if (stop) state_nx = IDLE;
        else if (hash_done) state_nx = STREAM;
      end
      STREAM: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (last_xfer) begin
`ifdef SALSA_KS_PREFETCH_EN
          if (!pf_issued) state_nx = IDLE;
          else if (!sh_valid) state_nx = HASH;
`else
          if (ctr_max) state_nx = IDLE;
          else state_nx = HASH;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hash_key_out     <= '0;
      hash_nonce_out   <= '0;
      hash_counter_out <= '0;
      lat_cnt          <= '0;
      idx              <= '0;
      blk_q            <= '0;
      ctr_wrap         <= 1'b0;
`ifdef SALSA_KS_PREFETCH_EN
      shadow_q  <= '0;
      sh_valid  <= 1'b0;
      pf_busy   <= 1'b0;
      pf_issued <= 1'b0;
      pf_cnt    <= '0;
`endif
    end else begin
      if (accept) begin
        hash_key_out     <= cfg_key;
        hash_nonce_out   <= cfg_nonce;
        hash_counter_out <= cfg_counter;
        ctr_wrap         <= 1'b0;
        lat_cnt          <= '0;
`ifdef SALSA_KS_PREFETCH_EN
        pf_issued <= 1'b0;
`endif
      end
      if (state == HASH && !stop) begin
        lat_cnt <= lat_cnt + 4'd1;
        if (hash_done) begin
          blk_q <= hash_digest_in;
          idx   <= '0;
        end
      end
      if (xfer) begin
        blk_q <= {blk_q[479:0], 32'h0};
        idx   <= idx + 4'd1;
        if (ks_last && !stop) begin
`ifdef SALSA_KS_PREFETCH_EN
          if (!pf_issued) begin
            ctr_wrap <= 1'b1;
          end else if (!sh_valid) begin
            lat_cnt <= '0;
            pf_busy <= 1'b0;
          end
`else
          if (ctr_max) begin
            ctr_wrap <= 1'b1;
          end else begin
            hash_counter_out <= hash_counter_out + 64'd1;
            lat_cnt          <= '0;
          end
`endif
        end
      end
`ifdef SALSA_KS_PREFETCH_EN
      if (pf_busy) begin
        if (pf_cnt == 4'd0) begin
          shadow_q <= hash_digest_in;
          sh_valid <= 1'b1;
          pf_busy  <= 1'b0;
        end else begin
          pf_cnt <= pf_cnt - 4'd1;
        end
      end
      // Each block entering STREAM launches the hash of its successor.
      if (pf_start) begin
        if (!ctr_max) begin
          hash_counter_out <= hash_counter_out + 64'd1;
          pf_busy          <= 1'b1;
          pf_cnt           <= LAT_M1;
          pf_issued        <= 1'b1;
        end else begin
          pf_issued <= 1'b0;
        end
      end
      if (swap) begin
        blk_q    <= shadow_q;
        sh_valid <= 1'b0;
      end
      if (stop && state != IDLE) begin
        sh_valid  <= 1'b0;
        pf_busy   <= 1'b0;
        pf_issued <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/salsa_keystream_ctrl.md
# salsa_keystream_ctrl

Sequencer that drives the combinational/pipelined `salsa_hash` core to generate a Salsa20 keystream. It accepts a key/nonce/start-counter configuration and steps the 64-bit block counter. It captures each 512-bit digest and serves it as sixteen 32-bit words over a valid/ready stream. It sits between the cipher XOR stage (consumer) and the `salsa_hash` instance (external, wired to the `hash_*` ports).

## Interface

**Parameters**
- `HASH_LAT`, default 1: cycles from a stable `hash_*` input to a valid `hash_digest_in`. Legal range 1..15.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous and active-high.
- `cfg_valid`, in, 1: configuration offer.
- `cfg_ready`, out, 1: high only in IDLE.
- `cfg_key`, in, 256: key.
- `cfg_nonce`, in, 64: nonce.
- `cfg_counter`, in, 64: first block counter.
- `stop`, in, 1: abort the current stream.
- `hash_key_out`, out, 256: to `salsa_hash.key_in`. Registered.
- `hash_nonce_out`, out, 64: to `salsa_hash.nonce_in`. Registered.
- `hash_counter_out`, out, 64: to `salsa_hash.counter_in`. Registered.
- `hash_digest_in`, in, 512: from `salsa_hash.digest_out`.
- `ks_valid`, out, 1: keystream word valid.
- `ks_ready`, in, 1: consumer ready.
- `ks_data`, out, 32: keystream word.
- `ks_last`, out, 1: marks word 15 of a block.
- `busy`, out, 1: state is not IDLE.
- `ctr_wrap`, out, 1: sticky flag. Set when the counter is exhausted; cleared by `rst` or by the next cfg accept.

## Operation

**States:** IDLE, HASH, STREAM.

**Reset values**
- All outputs 0, except `cfg_ready` = 1.
- State IDLE.
- `hash_*` regs and internal counters 0.

**IDLE**
- On `cfg_valid && cfg_ready`: latch key/nonce/counter into the `hash_*` regs, clear `ctr_wrap`, go to HASH.

**HASH**
- Count HASH_LAT cycles.
- On the last one, capture `hash_digest_in` into the stream buffer, set word index to 0, go to STREAM.

**STREAM**
- Word i = `digest[511-32*i -: 32]`.
- A word transfers on `ks_valid && ks_ready`; the index then increments.
- `ks_last` = (index == 15).

**Block completion** (transfer while `ks_last`):
- If `hash_counter_out` == 64'hFFFF_FFFF_FFFF_FFFF: set `ctr_wrap` and go to IDLE. No wrap to 0 and no further blocks.
- Otherwise increment `hash_counter_out` by 1 (64-bit) and go to HASH.

**Backpressure**
- While `ks_valid && !ks_ready`, `ks_data` and `ks_last` hold stable.

**`stop`**
- Sampled in HASH or STREAM: the next state is IDLE and `ks_valid` is low the next cycle.
- Simultaneous `stop` and a transfer: the word counts as transferred, the counter is not advanced, and the state goes to IDLE.

**`rst` mid-operation**
- Overrides everything. Returns to reset values on the same edge.

**Other rules**
- `cfg_valid` outside IDLE is ignored.
- `stop` in IDLE has no effect.

## Timing

- The cfg handshake at edge E0 puts new `hash_*` values on the outputs in the cycle after E0.
- The digest is captured at edge E0+HASH_LAT. `ks_valid` is first high in the cycle following that edge.
- Without prefetch, the last-word transfer at edge L leaves `ks_valid` low for HASH_LAT cycles. The next block's word 0 is valid after edge L+HASH_LAT.
- `busy` follows state with no extra latency.
- Throughput with prefetch: 1 word/cycle sustained.
- Throughput without prefetch: 16 words per 16+HASH_LAT cycles.

## Configuration

- Macro: `SALSA_KS_PREFETCH_EN`.

**Defined**
- A second 512-bit shadow buffer is added.
- When STREAM is entered, `hash_counter_out` is advanced immediately, unless the current counter is all-ones.
- The next digest is captured into the shadow buffer HASH_LAT cycles later.
- On the last-word transfer the shadow buffer is swapped in. `ks_valid` stays high with no bubble.
- `stop` discards the shadow buffer.
- The wrap rule is unchanged: after the all-ones block completes, `ctr_wrap` is set and the state goes to IDLE with no prefetch.

**Undefined**
- Single buffer and the HASH bubble as described under Operation.

## Test plan

1. **Baseline stream:** `rst`, then cfg key=256'h80, nonce=0, counter=0, `ks_ready`=1. Expected:
   - word0 = 32'h17A1F17E;
   - word15 = 32'hDD8FBEE3 with `ks_last`=1;
   - next block word0 = 32'hAE48E353 and `hash_counter_out`=1.
2. **Backpressure:** as scenario 1, with `ks_ready` low for 5 cycles at word 3 (32'h832A6544). Expected: `ks_data` held at 32'h832A6544 with `ks_valid`=1 throughout; no word skipped or duplicated.
3. **Counter wrap:** cfg_counter=64'hFFFF_FFFF_FFFF_FFFF, drain 16 words. Expected: `ctr_wrap`=1, `busy`=0, `cfg_ready`=1, `ks_valid` stays 0.
4. **Stop with transfer:** `stop` asserted together with the word-7 transfer. Expected:
   - next cycle `ks_valid`=0, `busy`=0;
   - `hash_counter_out` unchanged;
   - a new cfg is accepted.
5. **Reset mid-stream:** `rst` at word 10. Expected: next cycle all outputs at reset values; `cfg_valid` during reset is not accepted.
6. **Prefetch gap:** with `SALSA_KS_PREFETCH_EN` defined, HASH_LAT=1, `ks_ready`=1. Expected: 32 consecutive `ks_valid` cycles across blocks 0 and 1. Without the macro, a 1-cycle gap after `ks_last`.
